op_encoder_reg: RTL and testbench
=================================

OP_ENCODER_REG -- requirements
Module: op_encoder_reg

Interface
REQ-001 Parameter N, default 9: width of the one-hot request input; legal range 2..16.
REQ-002 Parameter W, default 4: op code width; SHALL satisfy 2**W >= N.
REQ-003 Parameter MODE, default 0: 0 = strict one-hot, where multi-hot is an error; 1 = priority, where the lowest set bit wins.
REQ-004 Parameter DEFAULT_OP, default 0: op value after reset.
REQ-005 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-006 rst_n  input  1  reset; asynchronous, active-low.
REQ-007 in  input  N  request lines, synchronous to clk; bit i requests op i.
REQ-008 op_ready  input  1  consumer accepts the op when op_valid and op_ready are both 1 at a rising edge.
REQ-009 clr  input  1  synchronous clear of err and ovf.
REQ-010 op  output  W  registered binary code of the last captured request.
REQ-011 op_valid  output  1  op holds a captured code not yet accepted.
REQ-012 err  output  1  sticky: a multi-hot request was rejected (MODE=0 only).
REQ-013 ovf  output  1  sticky: a request was dropped because an unaccepted op was pending.
REQ-014 acc_cnt  output  8  count of accepted ops; wraps modulo 256.

Function
REQ-015 Internal register in_q SHALL hold the value of in sampled at the previous edge; reset value 0.
REQ-016 A request event SHALL be in != 0 && in_q == 0, i.e. a rising edge from idle; holding in constant SHALL produce no further events.
REQ-017 Encoding in MODE=0: exactly one bit i set -> code i.
REQ-018 Multi-hot in MODE=0: no capture; err SHALL set at that edge; op and op_valid are unchanged.
REQ-019 Encoding in MODE=1: code = index of the lowest set bit; err SHALL never set.
REQ-020 Latency: for an event evaluated at edge t, op and op_valid=1 SHALL be visible after edge t, i.e. 1 cycle.
REQ-021 Output state machine states: IDLE (op_valid=0) and PEND (op_valid=1).
REQ-022 IDLE + event -> PEND, capturing op.
REQ-023 PEND + op_ready + no event -> IDLE; acc_cnt += 1.
REQ-024 PEND + op_ready + event -> stay in PEND with the new op; acc_cnt += 1. The accept and the new capture SHALL complete at the same edge.
REQ-025 PEND + !op_ready + event -> stay in PEND; op unchanged; new request dropped; ovf sets.
REQ-026 In IDLE, op SHALL retain the last captured code; the accumulator keeps the current operation.
REQ-027 op SHALL remain stable while op_valid=1 and op_ready=0.
REQ-028 op_ready while IDLE SHALL have no effect.
REQ-029 clr=1 SHALL clear err and ovf at the next edge; a set condition at the same edge SHALL win, leaving the flag at 1.
REQ-030 acc_cnt SHALL wrap 255 -> 0 with no flag.
REQ-031 A code i with i >= N is unreachable; op SHALL never exceed N-1.

Reset
REQ-032 While rst_n=0, asynchronously: op=DEFAULT_OP, op_valid=0, err=0, ovf=0, acc_cnt=0, in_q=0, state IDLE.
REQ-033 Reset asserted mid-PEND SHALL discard the pending op with no accept counted.
REQ-034 After release, an in value already nonzero SHALL count as an event at the first edge, because in_q=0.

Verification
REQ-035 Defaults, MODE=0, op_ready=1: in=9'b000010000 for 3 cycles, then 0 -> one op_valid pulse of 1 cycle; op=4; acc_cnt=1; op stays 4 afterwards.
REQ-036 MODE=0: in=9'b000000101 -> op_valid stays 0; err=1; op unchanged. Then clr=1 for 1 cycle -> err=0. MODE=1 with the same stimulus -> op=0, err=0.
REQ-037 op_ready=0: event in=bit3, then idle, then event in=bit7 -> op=3, op_valid=1, ovf=1. Raise op_ready -> accepted op=3, acc_cnt=1.
REQ-038 Simultaneous case: PEND with op=2; at one edge op_ready=1 and event in=bit8 -> op=8, op_valid=1, acc_cnt incremented by 1.
REQ-039 Reset case: in PEND with op=5, pulse rst_n=0 between clock edges -> immediately op=DEFAULT_OP, op_valid=0, acc_cnt=0. 256 accepts after reset -> acc_cnt=0.

Source files
------------

// File: rtl/op_encoder_reg_if.sv
// Request/op handshake bundle for op_encoder_reg.
// The master side drives the request lines, op_ready and clr.
// The slave side (the encoder) drives the registered op and its status.
interface op_encoder_reg_if #(
  parameter int N = 9,
  parameter int W = 4
);
  logic [N-1:0] in;
  logic         op_ready;
  logic         clr;
  logic [W-1:0] op;
  logic         op_valid;
  logic         err;
  logic         ovf;
  logic [7:0]   acc_cnt;

  modport master (
    output in, op_ready, clr,
    input  op, op_valid, err, ovf, acc_cnt
  );

  modport slave (
    input  in, op_ready, clr,
    output op, op_valid, err, ovf, acc_cnt
  );
endinterface

// File: rtl/op_encoder_reg.sv
// Edge-triggered one-hot/priority request encoder with a one-deep output
// register and a valid/ready handshake.
//
//   state | meaning
//   IDLE  | no op pending, op_valid=0, op keeps the last captured code
//   PEND  | captured op waiting for op_ready, op_valid=1
//
// Only a rising edge from an all-zero request vector counts as an event, so
// a request held high is captured once. When the consumer accepts and a new
// event arrives at the same edge, the new code replaces the accepted one
// without a bubble.
module op_encoder_reg #(
  parameter int N          = 9,
  parameter int W          = 4,
  parameter int MODE       = 0,
  parameter int DEFAULT_OP = 0
) (
  input logic             clk,
  input logic             rst_n,
  op_encoder_reg_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

  state_t       state;
  logic [N-1:0] in_q;
  logic [W-1:0] op_r;
  logic         op_valid_r;
  logic         err_r;
  logic         ovf_r;
  logic [7:0]   acc_cnt_r;

  logic [W-1:0] code;
  logic         req_event;
  logic         multi_hot;
  logic         capture;
  logic         err_set;
  logic         ovf_set;

  // Lowest set request bit wins; in strict mode this is only used when
  // exactly one bit is set, so the same encoder serves both modes.
  always_comb begin
    code = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.in[i]) code = W'(i);
    end
  end

  // Event detection and the capture / error / overflow decisions.
  always_comb begin
    req_event = (|bus.in) && !(|in_q);
    multi_hot = |(bus.in & (bus.in - N'(1)));
    capture   = req_event && !((MODE == 0) && multi_hot);
    err_set   = req_event && (MODE == 0) && multi_hot;
    ovf_set   = capture && (state == PEND) && !bus.op_ready;
  end

  // Request history, sticky flags, output FSM and accept counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_q       <= '0;
      op_r       <= W'(DEFAULT_OP);
      op_valid_r <= 1'b0;
      err_r      <= 1'b0;
      ovf_r      <= 1'b0;
      acc_cnt_r  <= 8'd0;
    end else begin
      in_q <= bus.in;

      if (err_set)      err_r <= 1'b1;
      else if (bus.clr) err_r <= 1'b0;

      if (ovf_set)      ovf_r <= 1'b1;
      else if (bus.clr) ovf_r <= 1'b0;

      case (state)
        IDLE: begin
          if (capture) begin
            op_r       <= code;
            op_valid_r <= 1'b1;
            state      <= PEND;
          end
        end
        PEND: begin
          if (bus.op_ready) begin
            acc_cnt_r <= acc_cnt_r + 8'd1;
            if (capture) begin
              op_r <= code;
            end else begin
              op_valid_r <= 1'b0;
              state      <= IDLE;
            end
          end
        end
        default: begin
          op_valid_r <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  assign bus.op       = op_r;
  assign bus.op_valid = op_valid_r;
  assign bus.err      = err_r;
  assign bus.ovf      = ovf_r;
  assign bus.acc_cnt  = acc_cnt_r;

endmodule

// File: tb/tb_op_encoder_reg.sv
// Bench for op_encoder_reg: a strict-mode and a priority-mode instance see
// the same directed stimulus; a rule-level model is compared against both
// every cycle, and literal expectations pin the key scenarios.
module tb_op_encoder_reg;

  logic clk;
  logic rst_n;

  op_encoder_reg_if #(.N(9), .W(4)) bus0 ();
  op_encoder_reg_if #(.N(9), .W(4)) bus1 ();

  op_encoder_reg #(.N(9), .W(4), .MODE(0), .DEFAULT_OP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave)
  );
  op_encoder_reg #(.N(9), .W(4), .MODE(1), .DEFAULT_OP(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] in_v;
  logic       rdy;
  logic       clr;

  always_comb begin
    bus0.in = in_v; bus0.op_ready = rdy; bus0.clr = clr;
    bus1.in = in_v; bus1.op_ready = rdy; bus1.clr = clr;
  end

  typedef struct {
    int   op;
    bit   valid;
    bit   err;
    bit   ovf;
    int   acc;
    logic [8:0] prev;
  } model_t;

  model_t m0, m1;

  function automatic model_t model_reset();
    model_t s;
    s.op = 0; s.valid = 0; s.err = 0; s.ovf = 0; s.acc = 0; s.prev = '0;
    return s;
  endfunction

  // Rule-level next state: event = rise from idle, strict mode rejects
  // multi-hot, lowest set bit gives the code, one-deep pending slot.
  function automatic model_t model_next(model_t s, int mode, logic [8:0] v,
                                        bit ready, bit clear);
    model_t n = s;
    bit ev, multi, good;
    ev    = (v != 0) && (s.prev == 0);
    multi = $countones(v) > 1;
    good  = ev && !(mode == 0 && multi);
    n.prev = v;
    if (clear) begin n.err = 0; n.ovf = 0; end
    if (ev && mode == 0 && multi) n.err = 1;
    if (s.valid && ready) begin
      n.acc   = (s.acc + 1) % 256;
      n.valid = 0;
    end
    if (good) begin
      if (!s.valid || ready) begin
        n.op    = $clog2(int'(v & (~v + 9'd1)));
        n.valid = 1;
      end else begin
        n.ovf = 1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0 = model_reset();
      m1 = model_reset();
    end else begin
      m0 = model_next(m0, 0, in_v, rdy, clr);
      m1 = model_next(m1, 1, in_v, rdy, clr);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("m0.op",       32'(bus0.op),       32'(m0.op));
    chk("m0.op_valid", 32'(bus0.op_valid), 32'(m0.valid));
    chk("m0.err",      32'(bus0.err),      32'(m0.err));
    chk("m0.ovf",      32'(bus0.ovf),      32'(m0.ovf));
    chk("m0.acc_cnt",  32'(bus0.acc_cnt),  32'(m0.acc));
    chk("m1.op",       32'(bus1.op),       32'(m1.op));
    chk("m1.op_valid", 32'(bus1.op_valid), 32'(m1.valid));
    chk("m1.err",      32'(bus1.err),      32'(m1.err));
    chk("m1.ovf",      32'(bus1.ovf),      32'(m1.ovf));
    chk("m1.acc_cnt",  32'(bus1.acc_cnt),  32'(m1.acc));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    in_v = '0; rdy = 1'b0; clr = 1'b0;
    rst_n = 1'b0;
    #12;
    chk("reset op",       32'(bus0.op),       32'd0);
    chk("reset op_valid", 32'(bus0.op_valid), 32'd0);
    chk("reset acc_cnt",  32'(bus0.acc_cnt),  32'd0);
    rst_n = 1'b1;
    step();

    // Held one-hot request: single capture, single accept.
    rdy = 1'b1; in_v = 9'b000010000;
    step();
    chk("hold op",        32'(bus0.op),       32'd4);
    chk("hold valid",     32'(bus0.op_valid), 32'd1);
    step();
    chk("hold accepted",  32'(bus0.op_valid), 32'd0);
    chk("hold acc_cnt",   32'(bus0.acc_cnt),  32'd1);
    step();
    chk("hold no re-fire", 32'(bus0.op_valid), 32'd0);
    in_v = '0;
    step();
    chk("hold op kept",   32'(bus0.op),       32'd4);
    chk("hold acc final", 32'(bus0.acc_cnt),  32'd1);

    // Multi-hot request: strict rejects with err, priority picks bit 0.
    in_v = 9'b000000101;
    step();
    chk("multi strict valid", 32'(bus0.op_valid), 32'd0);
    chk("multi strict err",   32'(bus0.err),      32'd1);
    chk("multi strict op",    32'(bus0.op),       32'd4);
    chk("multi prio op",      32'(bus1.op),       32'd0);
    chk("multi prio err",     32'(bus1.err),      32'd0);
    chk("multi prio valid",   32'(bus1.op_valid), 32'd1);
    in_v = '0; clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr err",            32'(bus0.err),      32'd0);

    // Overflow: second request dropped while first is pending.
    rdy = 1'b0; in_v = 9'b000001000;
    step();
    in_v = '0;
    step();
    in_v = 9'b010000000;
    step();
    chk("ovf op",    32'(bus0.op),       32'd3);
    chk("ovf valid", 32'(bus0.op_valid), 32'd1);
    chk("ovf flag",  32'(bus0.ovf),      32'd1);
    in_v = '0; rdy = 1'b1;
    step();
    chk("ovf accepted", 32'(bus0.op_valid), 32'd0);
    chk("ovf acc_cnt",  32'(bus0.acc_cnt),  32'd2);

    // Accept and new capture at the same edge.
    rdy = 1'b0; in_v = 9'b000000100;
    step();
    chk("sim op2", 32'(bus0.op), 32'd2);
    in_v = '0;
    step();
    rdy = 1'b1; in_v = 9'b100000000;
    step();
    chk("sim op8",    32'(bus0.op),       32'd8);
    chk("sim valid",  32'(bus0.op_valid), 32'd1);
    chk("sim acc",    32'(bus0.acc_cnt),  32'd3);
    chk("sim ovf",    32'(bus0.ovf),      32'd1);
    in_v = '0; clr = 1'b1;
    step();
    clr = 1'b0;
    chk("sim drain acc", 32'(bus0.acc_cnt), 32'd4);
    chk("clr ovf",       32'(bus0.ovf),     32'd0);

    // Clear and set at the same edge: set wins.
    rdy = 1'b0; in_v = 9'b000000011; clr = 1'b1;
    step();
    clr = 1'b0; in_v = '0;
    chk("clr vs set err", 32'(bus0.err), 32'd1);
    rdy = 1'b1;
    step();

    // Asynchronous reset mid-PEND, with request held through release.
    rdy = 1'b0; in_v = 9'b000100000;
    step();
    chk("pre-reset op", 32'(bus0.op), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("async op",       32'(bus0.op),       32'd0);
    chk("async op_valid", 32'(bus0.op_valid), 32'd0);
    chk("async acc_cnt",  32'(bus0.acc_cnt),  32'd0);
    chk("async err",      32'(bus0.err),      32'd0);
    #1 rst_n = 1'b1;
    step();
    chk("post-reset event op",    32'(bus0.op),       32'd5);
    chk("post-reset event valid", 32'(bus0.op_valid), 32'd1);
    chk("post-reset acc",         32'(bus0.acc_cnt),  32'd0);

    // 256 accepts wrap the counter back to zero.
    rdy = 1'b1; in_v = '0;
    step();
    for (int i = 0; i < 255; i++) begin
      in_v = 9'(1 << (i % 9));
      step();
      in_v = '0;
      step();
    end
    chk("wrap acc0", 32'(bus0.acc_cnt), 32'd0);
    chk("wrap acc1", 32'(bus1.acc_cnt), 32'd0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
